// File: rtl/exec_unit.sv
// exec_unit: register file, operand-2 mux and multi-op ALU with a valid/ready
// issue handshake and a registered writeback strobe. Single-issue, one
// instruction in flight.
// Optional feature macro: EXEC_MUL_EN -- when defined, ALUctrl=111 runs an
// iterative shift-add multiplier (IDLE/MUL/WB FSM, D_WIDTH steps). When
// undefined, the multiplier is removed, busy is tied low and ALUctrl=111
// executes as ADD in a single cycle.
module exec_unit #(
  parameter int D_WIDTH  = 32,
  parameter int R_ADDR_W = 5,
  parameter int A0_IDX   = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [R_ADDR_W-1:0] rs1,
  input  logic [R_ADDR_W-1:0] rs2,
  input  logic [R_ADDR_W-1:0] rd,
  input  logic                ALUsrc,
  input  logic [2:0]          ALUctrl,
  input  logic [D_WIDTH-1:0]  ImmOp,
  input  logic                RegWrite,
  output logic                EQ,
  output logic                busy,
  output logic                wb_valid,
  output logic [D_WIDTH-1:0]  a0
);

  localparam int NREGS = 2 ** R_ADDR_W;
  localparam int SH_W  = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [R_ADDR_W-1:0] A0_ADDR = R_ADDR_W'(A0_IDX);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [D_WIDTH-1:0]  regs [NREGS];
  logic [D_WIDTH-1:0]  rs1_val;
  logic [D_WIDTH-1:0]  rs2_val;
  logic [D_WIDTH-1:0]  op2;
  logic [D_WIDTH-1:0]  alu_res;
  logic                accept;
  logic                is_mul;
  logic                single_wr;
  logic                wr_en;
  logic [R_ADDR_W-1:0] wr_addr;
  logic [D_WIDTH-1:0]  wr_data;

  // Operand fetch: x0 is hard-wired to zero regardless of storage contents.
  assign rs1_val = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs[rs2];
  assign op2     = ALUsrc ? ImmOp : rs2_val;
  assign EQ      = (rs1_val == op2);
  assign a0      = regs[A0_ADDR];
  assign accept  = in_valid && in_ready;

  // Single-cycle ALU; MUL falls through to ADD here and is handled separately.
  always_comb begin
    // NOTE: assign every always_comb output before the case so no path leaves it unassigned (no latch).
    alu_res = rs1_val + op2;
    case (ALUctrl)
      OP_ADD: alu_res = rs1_val + op2;
      OP_SUB: alu_res = rs1_val - op2;
      OP_AND: alu_res = rs1_val & op2;
      OP_OR:  alu_res = rs1_val | op2;
      OP_XOR: alu_res = rs1_val ^ op2;
      OP_SLT: alu_res = {{(D_WIDTH-1){1'b0}}, ($signed(rs1_val) < $signed(op2))};
      OP_SLL: alu_res = rs1_val << op2[SH_W-1:0];
      OP_MUL: alu_res = rs1_val + op2;
      default: alu_res = rs1_val + op2;
    endcase
  end

  assign single_wr = accept && !is_mul && RegWrite && (rd != '0);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

  localparam logic [SH_W-1:0] LAST_STEP = SH_W'(D_WIDTH - 1);

  state_t              state;
  state_t              state_nx;
  logic [D_WIDTH-1:0]  m_mcand;
  logic [D_WIDTH-1:0]  m_mplier;
  logic [D_WIDTH-1:0]  m_acc;
  logic [SH_W-1:0]     m_cnt;
  logic [R_ADDR_W-1:0] m_rd;
  logic                m_we;
  logic                mul_wr;

  assign is_mul   = (ALUctrl == OP_MUL);
  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);
  assign mul_wr   = (state == S_WB) && m_we && (m_rd != '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state: a MUL issue walks IDLE -> MUL (D_WIDTH steps) -> WB -> IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nx = S_MUL;
      S_MUL:   if (m_cnt == LAST_STEP) state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift-add multiplier: capture operands on issue, one partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_mcand  <= '0;
      m_mplier <= '0;
      m_acc    <= '0;
      m_cnt    <= '0;
      m_rd     <= '0;
      m_we     <= 1'b0;
    end else if (accept && is_mul) begin
      m_mcand  <= rs1_val;
      m_mplier <= op2;
      m_acc    <= '0;
      m_cnt    <= '0;
      m_rd     <= rd;
      m_we     <= RegWrite;
    end else if (state == S_MUL) begin
      if (m_mplier[0]) m_acc <= m_acc + m_mcand;
      m_mcand  <= m_mcand << 1;
      m_mplier <= m_mplier >> 1;
      m_cnt    <= m_cnt + SH_W'(1);
    end
  end

  // The FSM blocks issue while in MUL/WB, so the two write sources never collide.
  assign wr_en   = single_wr || mul_wr;
  assign wr_addr = mul_wr ? m_rd  : rd;
  assign wr_data = mul_wr ? m_acc : alu_res;
`else
  assign is_mul   = 1'b0;
  assign in_ready = !rst;
  assign busy     = 1'b0;
  assign wr_en    = single_wr;
  assign wr_addr  = rd;
  assign wr_data  = alu_res;
`endif

  // Register file write port; reset clears every entry.
  always_ff @(posedge clk) begin
    // NOTE: the register array is reset explicitly because software relies on all registers starting at zero.
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Writeback strobe: one-cycle pulse in the cycle after a committed write.
  always_ff @(posedge clk) begin
    if (rst) wb_valid <= 1'b0;
    else     wb_valid <= wr_en;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Parametrised successor to the single-cycle reduced RISC-V datapath slice: register file, operand-2 mux and ALU in one block.
- Adds a multi-op ALU, configurable register count, a valid/ready issue handshake, a registered writeback strobe and an iterative multi-cycle multiplier.
- Sits between the control unit/instruction memory and the top-level a0 output; single-issue, one instruction in flight.

Parameters:
D_WIDTH, 32, datapath and register width
R_ADDR_W, 5, register address width; register count = 2**R_ADDR_W
A0_IDX, 10, register index driven onto a0

Ports:
clk  input  1  main clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  instruction fields valid this cycle
in_ready  output  1  block can accept an instruction this cycle
rs1  input  R_ADDR_W  source register 1 address
rs2  input  R_ADDR_W  source register 2 address
rd  input  R_ADDR_W  destination register address
ALUsrc  input  1  0: op2 = reg[rs2], 1: op2 = ImmOp
ALUctrl  input  3  operation select
ImmOp  input  D_WIDTH  immediate operand
RegWrite  input  1  write result to rd
EQ  output  1  combinational reg[rs1] == op2 (post-mux)
busy  output  1  multiplier FSM not IDLE
wb_valid  output  1  one-cycle pulse after each committed register write
a0  output  D_WIDTH  contents of reg[A0_IDX]

Behaviour:
- Reset: all registers cleared to 0; FSM to IDLE; a0=0, wb_valid=0, busy=0, in_ready=0 while rst=1.
- in_ready = (state==IDLE) && !rst. Accept = in_valid && in_ready. Fields sampled only on accept; ignored otherwise.
- Register reads combinational; reg[0] always reads 0, writes to rd=0 discarded (no wb_valid).
- ALUctrl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 0/1), 110 SLL (shift by op2[log2(D_WIDTH)-1:0]), 111 MUL.
- Arithmetic modulo 2**D_WIDTH; no overflow flag.
- Single-cycle ops: on accept in cycle T with RegWrite=1, rd!=0: reg[rd] written at end of T; a0 (if rd==A0_IDX) and wb_valid=1 visible in T+1; wb_valid low in T+2 unless another write commits.
- Back-to-back single-cycle ops: one per cycle; instruction in T+1 reads value written in T.
- MUL FSM states IDLE, MUL, WB:
  - IDLE -> MUL on accepted ALUctrl=111; op1/op2 captured, counter=0.
  - MUL: one shift-add step per cycle, D_WIDTH cycles; counter==D_WIDTH-1 -> WB.
  - WB: low D_WIDTH bits of product written if captured RegWrite=1 and rd!=0, then -> IDLE.
  - Timing (accept at T): in_ready low T+1..T+D_WIDTH+1; result and wb_valid visible T+D_WIDTH+2.
- EQ: combinational in every state from current rs1/rs2/ALUsrc/ImmOp.
- Reset mid-MUL: FSM -> IDLE next cycle; product discarded; no write, no wb_valid.
- rst dominates a simultaneous accept.

Optional Feature:
EXEC_MUL_EN
- Defined: MUL FSM present as above.
- Undefined: FSM, multiplier and busy logic removed; busy tied 0; in_ready = !rst; ALUctrl=111 executes as ADD in a single cycle.

Test Plan:
1. rst high 2 cycles, then low -> a0=0, wb_valid=0, busy=0; in_ready=0 during reset, 1 the cycle after release.
2. ADD, ALUsrc=1, ImmOp=5, rs1=0, rd=10, RegWrite=1 accepted at T -> a0=5 and wb_valid=1 at T+1; wb_valid=0 at T+2.
3. Load x1=0xFFFFFFFD, x2=2. Then:
   - SLT rd=10, rs1=1, rs2=2 -> a0=1.
   - SUB rd=10, rs1=2, rs2=1 -> a0=5.
   - rs1=rs2=2, ALUsrc=0 -> EQ=1.
   - ALUsrc=1, ImmOp=3 -> EQ=0.
4. x1=7, x2=6; MUL rd=10 accepted at T, in_valid held high afterwards -> in_ready=0 and busy=1 T+1..T+33; no extra accept; a0=42 and wb_valid=1 at T+34.
5. MUL 0x00010000 * 0x00010000 -> a0=0; 0xFFFFFFFF * 2 -> a0=0xFFFFFFFE.
6. ADD rd=0, ImmOp=9 -> reg[0] still reads 0, wb_valid stays 0. Then MUL with rst asserted at T+10 -> a0=0, no wb_valid, in_ready=1 the cycle after rst drops.
